// File: rtl/multiplier32_seq_pkg.sv
// Shared types for the sequential 32-bit RISC-V M-extension multiplier.
// Holds op/state encodings, XLEN and the accept-time magnitude helper.
package multiplier32_seq_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FIX_LO,
        FIX_HI,
        DONE
    } state_e;

    // 0x80000000 maps to itself and is then read as unsigned.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/multiplier32_seq_if.sv
// Request/response bundle between a requester and multiplier32_seq.
// master = requester side, slave = multiplier side.
interface multiplier32_seq_if;
    import multiplier32_seq_pkg::*;

    logic            in_valid;
    logic            in_ready;
    op_e             op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/multiplier32_seq_adder32.sv
// Shared 32-bit adder; carry-out rebuilt from the MSB operands and sum.
// Used for both shift-add accumulation and two's-complement fix-up.
module multiplier32_seq_adder32
    import multiplier32_seq_pkg::*;
(
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    input  logic            cin,
    output logic [XLEN-1:0] sum,
    output logic            cout
);

    assign sum  = x + y + XLEN'(cin);
    assign cout = (x[XLEN-1] & y[XLEN-1])
                | ((x[XLEN-1] | y[XLEN-1]) & ~sum[XLEN-1]);

endmodule

// File: rtl/multiplier32_seq.sv
// Sequential shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Fixed 34-cycle latency: 32 RUN steps plus two sign fix-up cycles.
module multiplier32_seq
    import multiplier32_seq_pkg::*;
(
    input logic               clk,
    input logic               reset_n,
    multiplier32_seq_if.slave bus
);

    state_e          state;
    state_e          state_nx;
    op_e             op_q;
    logic            neg_q;
    logic            carry_q;
    logic [4:0]      cnt;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] mcand;

    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            neg_in;

    logic [XLEN-1:0] add_x;
    logic [XLEN-1:0] add_y;
    logic [XLEN-1:0] add_sum;
    logic            add_cin;
    logic            add_cout;

    always_comb begin
        a_mag  = bus.a;
        b_mag  = bus.b;
        neg_in = 1'b0;
        unique case (bus.op)
            MUL, MULH: begin
                a_mag  = mag(bus.a);
                b_mag  = mag(bus.b);
                neg_in = bus.a[XLEN-1] ^ bus.b[XLEN-1];
            end
            MULHSU: begin
                a_mag  = mag(bus.a);
                neg_in = bus.a[XLEN-1];
            end
            default: ;
        endcase
    end

    // One adder serves accumulate (RUN) and ~x+c negation (FIX_*).
    always_comb begin
        add_x   = hi;
        add_y   = '0;
        add_cin = 1'b0;
        unique case (state)
            RUN:    add_y = lo[0] ? mcand : '0;
            FIX_LO: begin
                add_x   = ~lo;
                add_cin = 1'b1;
            end
            FIX_HI: begin
                add_x   = ~hi;
                add_cin = carry_q;
            end
            default: ;
        endcase
    end

    multiplier32_seq_adder32 u_adder32 (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nx = RUN;
            RUN:     if (cnt == 5'd31) state_nx = FIX_LO;
            FIX_LO:  state_nx = FIX_HI;
            FIX_HI:  state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= MUL;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            mcand   <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    op_q    <= bus.op;
                    neg_q   <= neg_in;
                    carry_q <= 1'b0;
                    cnt     <= '0;
                    hi      <= '0;
                    lo      <= b_mag;
                    mcand   <= a_mag;
                end
                RUN: begin
                    hi  <= {add_cout, add_sum[XLEN-1:1]};
                    lo  <= {add_sum[0], lo[XLEN-1:1]};
                    cnt <= cnt + 5'd1;
                end
                FIX_LO: if (neg_q) begin
                    lo      <= add_sum;
                    carry_q <= add_cout;
                end
                FIX_HI: if (neg_q) hi <= add_sum;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = (state != DONE) ? '0
                         : (op_q == MUL)   ? lo : hi;

endmodule
